ecc_20_wr_enc: RTL

//  Write-side ECC encoder for 20-bit FIFO/RAM data. Computes the 6-bit SEC-DED parity and emits a 26-bit codeword for storage.
//  It is the producer of the codewords that the read-side ecc_20 checker/corrector consumes.

---
 rtl/ecc_20_wr_enc.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ecc_20_wr_enc.sv
// Write-side SEC-DED encoder for 20-bit data: registered valid/ready stage producing
// {parity, data} codewords, with one-shot single/double-bit error injection and stat counters.
module ecc_20_wr_enc #(
    parameter int DATA_WIDTH   = 20,
    parameter int PARITY_WIDTH = 6,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_vld,
    output logic                               in_rdy,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic                               bypass,
    input  logic                               inj_sbit,
    input  logic                               inj_dbit,
    input  logic [4:0]                         inj_pos0,
    input  logic [4:0]                         inj_pos1,
    output logic                               inj_armed,
    output logic                               inj_done,
    output logic                               out_vld,
    input  logic                               out_rdy,
    output logic [DATA_WIDTH+PARITY_WIDTH-1:0] out_cw,
    output logic [CNT_WIDTH-1:0]               enc_cnt,
    output logic [7:0]                         inj_cnt
);
    localparam int CW = DATA_WIDTH + PARITY_WIDTH;

    typedef enum logic [1:0] {IDLE, ARM_S, ARM_D} inj_state_t;

    inj_state_t            r_state;
    inj_state_t            w_state_nxt;
    logic [4:0]            r_pos0;
    logic [4:0]            r_pos1;
    logic                  r_vld;
    logic [CW-1:0]         r_cw;
    logic                  r_done;
    logic [CNT_WIDTH-1:0]  r_enc_cnt;
    logic [7:0]            r_inj_cnt;

    logic                    w_accept;
    logic                    w_inj_apply;
    logic                    w_arm;
    logic [PARITY_WIDTH-1:0] w_parity;
    logic [CW-1:0]           w_mask;
    logic [CW-1:0]           w_cw;
    logic [4:0]              w_map0;
    logic [4:0]              w_map1;
    logic [4:0]              w_pos1_eff;

    function automatic logic [4:0] map_pos(input logic [4:0] p);
        return (p >= 5'd26) ? p - 5'd26 : p;
    endfunction

    assign in_rdy      = !r_vld | out_rdy;
    assign w_accept    = in_vld & in_rdy;
    assign w_inj_apply = w_accept & !bypass & (r_state != IDLE);
    assign w_arm       = (r_state == IDLE) & (inj_sbit | inj_dbit);

    assign w_parity[0] = in_data[0] ^ in_data[1] ^ in_data[3] ^ in_data[4] ^ in_data[6] ^ in_data[8]
                       ^ in_data[10] ^ in_data[11] ^ in_data[13] ^ in_data[15] ^ in_data[17] ^ in_data[19];
    assign w_parity[1] = in_data[0] ^ in_data[2] ^ in_data[3] ^ in_data[5] ^ in_data[6] ^ in_data[9]
                       ^ in_data[10] ^ in_data[12] ^ in_data[13] ^ in_data[16] ^ in_data[17];
    assign w_parity[2] = in_data[1] ^ in_data[2] ^ in_data[3] ^ in_data[7] ^ in_data[8] ^ in_data[9]
                       ^ in_data[10] ^ in_data[14] ^ in_data[15] ^ in_data[16] ^ in_data[17];
    assign w_parity[3] = in_data[4] ^ in_data[5] ^ in_data[6] ^ in_data[7] ^ in_data[8] ^ in_data[9]
                       ^ in_data[10] ^ in_data[18] ^ in_data[19];
    assign w_parity[4] = in_data[11] ^ in_data[12] ^ in_data[13] ^ in_data[14] ^ in_data[15]
                       ^ in_data[16] ^ in_data[17] ^ in_data[18] ^ in_data[19];
    assign w_parity[5] = in_data[0] ^ in_data[1] ^ in_data[2] ^ in_data[4] ^ in_data[5] ^ in_data[7]
                       ^ in_data[10] ^ in_data[11] ^ in_data[12] ^ in_data[14] ^ in_data[17] ^ in_data[18];

    // Positions are folded into range at arm time; a colliding dbit second position
    // is bumped so exactly two distinct bits flip.
    assign w_map0     = map_pos(inj_pos0);
    assign w_map1     = map_pos(inj_pos1);
    assign w_pos1_eff = (w_map1 != w_map0) ? w_map1 :
                        (w_map0 == 5'd25)  ? 5'd0 : w_map0 + 5'd1;

    always_comb begin
        w_mask = CW'(1) << r_pos0;
        if (r_state == ARM_D) begin
            w_mask = w_mask | (CW'(1) << r_pos1);
        end
    end

    always_comb begin
        if (bypass) begin
            w_cw = {{PARITY_WIDTH{1'b0}}, in_data};
        end else if (w_inj_apply) begin
            w_cw = {w_parity, in_data} ^ w_mask;
        end else begin
            w_cw = {w_parity, in_data};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (inj_dbit) begin
                    w_state_nxt = ARM_D;
                end else if (inj_sbit) begin
                    w_state_nxt = ARM_S;
                end
            end
            ARM_S, ARM_D: begin
                if (w_inj_apply) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pos0  <= '0;
            r_pos1  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arm) begin
                r_pos0 <= w_map0;
                r_pos1 <= w_pos1_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld     <= 1'b0;
            r_cw      <= '0;
            r_done    <= 1'b0;
            r_enc_cnt <= '0;
            r_inj_cnt <= '0;
        end else begin
            r_done <= w_inj_apply;
            if (w_accept) begin
                r_vld <= 1'b1;
                r_cw  <= w_cw;
                if (r_enc_cnt != '1) begin
                    r_enc_cnt <= r_enc_cnt + 1'b1;
                end
            end else if (out_rdy) begin
                r_vld <= 1'b0;
            end
            if (w_inj_apply && (r_inj_cnt != '1)) begin
                r_inj_cnt <= r_inj_cnt + 1'b1;
            end
        end
    end

    assign out_vld   = r_vld;
    assign out_cw    = r_cw;
    assign inj_done  = r_done;
    assign inj_armed = (r_state != IDLE);
    assign enc_cnt   = r_enc_cnt;
    assign inj_cnt   = r_inj_cnt;
endmodule
